// File: rtl/matrix_input_collector.sv
// rtl/matrix_input_collector.sv - collects an r x c matrix of range-checked elements into a flat buffer
//
// Purpose:
//   Accepts a dimension request (1..5 rows, 1..5 columns). It then gathers r*c
//   elements in arrival order into 25 fixed slots and flags completion with a
//   level 'done' until the consumer acknowledges. The block rejects illegal
//   dimensions (dim_err level) and out-of-range elements (value_err pulse).
//   'abort' cancels from any state. All outputs come straight from flops.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   start, r_in, c_in     begin a matrix with the requested dimensions (IDLE only)
//   in_valid, in_data     element offer; in_ready high while collecting
//   ack                   releases DONE or ERROR back to IDLE
//   abort                 cancel to IDLE from any state, clearing buffer and count
//   data_out              slot k on bits [k*DATA_WIDTH +: DATA_WIDTH], k = 0..24
//   r_out, c_out, count   latched dimensions and number of accepted elements
//   done, dim_err         status levels
//   value_err             one-cycle pulse after a rejected element
module matrix_input_collector #(
  parameter int DATA_WIDTH = 9,
  parameter int MAX_VAL    = 9
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [2:0]              r_in,
  input  logic [2:0]              c_in,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  input  logic                    ack,
  input  logic                    abort,
  output logic [25*DATA_WIDTH-1:0] data_out,
  output logic [2:0]              r_out,
  output logic [2:0]              c_out,
  output logic [4:0]              count,
  output logic                    done,
  output logic                    dim_err,
  output logic                    value_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MAX_VAL);

  state_t                    state_q, state_d;
  logic [25*DATA_WIDTH-1:0]  data_q, data_d;
  logic [2:0]                r_q, r_d;
  logic [2:0]                c_q, c_d;
  logic [4:0]                count_q, count_d;
  logic                      in_ready_q, in_ready_d;
  logic                      done_q, done_d;
  logic                      dim_err_q, dim_err_d;
  logic                      value_err_q, value_err_d;

  // Six bits so that the product of any 3-bit pair (up to 49) never wraps.
  logic [5:0] total;
  logic [5:0] count_inc;
  logic       dims_ok;
  logic       transfer;
  logic       in_range;

  assign total     = {3'b000, r_q} * {3'b000, c_q};
  assign count_inc = {1'b0, count_q} + 6'd1;
  assign dims_ok   = (r_in != 3'd0) && (r_in <= 3'd5) && (c_in != 3'd0) && (c_in <= 3'd5);
  // in_ready_q is only ever high in COLLECT, so it doubles as the state qualifier.
  assign transfer  = in_valid && in_ready_q;
  assign in_range  = (in_data <= MAX_V);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      r_q         <= '0;
      c_q         <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      dim_err_q   <= 1'b0;
      value_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      r_q         <= r_d;
      c_q         <= c_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      done_q      <= done_d;
      dim_err_q   <= dim_err_d;
      value_err_q <= value_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    r_d         = r_q;
    c_d         = c_q;
    count_d     = count_q;
    in_ready_d  = in_ready_q;
    done_d      = done_q;
    dim_err_d   = dim_err_q;
    value_err_d = 1'b0;

    if (abort) begin
      state_d    = S_IDLE;
      data_d     = '0;
      count_d    = '0;
      in_ready_d = 1'b0;
      done_d     = 1'b0;
      dim_err_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (dims_ok) begin
              state_d    = S_COLLECT;
              r_d        = r_in;
              c_d        = c_in;
              data_d     = '0;
              count_d    = '0;
              in_ready_d = 1'b1;
            end else begin
              state_d   = S_ERROR;
              dim_err_d = 1'b1;
            end
          end
        end

        S_COLLECT: begin
          if (transfer) begin
            if (in_range) begin
              // Decoded write keeps the slot index in range for every count value.
              for (int k = 0; k < 25; k++) begin
                if (count_q == 5'(k)) begin
                  data_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
                end
              end
              count_d = count_inc[4:0];
              if (count_inc == total) begin
                state_d    = S_DONE;
                in_ready_d = 1'b0;
                done_d     = 1'b1;
              end
            end else begin
              value_err_d = 1'b1;
            end
          end
        end

        S_DONE: begin
          if (ack) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
          end
        end

        S_ERROR: begin
          if (ack) begin
            state_d   = S_IDLE;
            dim_err_d = 1'b0;
          end
        end

        default: begin
          state_d    = S_IDLE;
          in_ready_d = 1'b0;
          done_d     = 1'b0;
          dim_err_d  = 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign r_out     = r_q;
  assign c_out     = c_q;
  assign count     = count_q;
  assign in_ready  = in_ready_q;
  assign done      = done_q;
  assign dim_err   = dim_err_q;
  assign value_err = value_err_q;

endmodule

// File: tb/tb_matrix_input_collector.sv
// tb/tb_matrix_input_collector.sv - directed self-checking bench for matrix_input_collector
module tb_matrix_input_collector;

  localparam int DW = 9;
  localparam int MV = 9;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [2:0]        r_in;
  logic [2:0]        c_in;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              ack;
  logic              abort;
  logic [25*DW-1:0]  data_out;
  logic [2:0]        r_out;
  logic [2:0]        c_out;
  logic [4:0]        count;
  logic              done;
  logic              dim_err;
  logic              value_err;

  int checks = 0;
  int errors = 0;
  int exp_slots [25];

  matrix_input_collector #(.DATA_WIDTH(DW), .MAX_VAL(MV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .r_in      (r_in),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ack       (ack),
    .abort     (abort),
    .data_out  (data_out),
    .r_out     (r_out),
    .c_out     (c_out),
    .count     (count),
    .done      (done),
    .dim_err   (dim_err),
    .value_err (value_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 25; k++) exp_slots[k] = 0;
  endtask

  function automatic logic [25*DW-1:0] exp_vec();
    logic [25*DW-1:0] v;
    v = '0;
    for (int k = 0; k < 25; k++) v[k*DW +: DW] = DW'(exp_slots[k]);
    return v;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; start = 0; r_in = 0; c_in = 0; in_valid = 0; in_data = 0; ack = 0; abort = 0;
    #2;
    checks++;
    if ({in_ready, done, dim_err, value_err, count, r_out, c_out} !== 16'h0 || data_out !== '0) begin
      errors++; $display("FAIL reset_initial: outputs not all zero (count=%0d r=%0d c=%0d)", count, r_out, c_out);
    end
    step();
    reset_n = 1'b1; start = 1; r_in = 5; c_in = 5;
    step();
    start = 0;
    checks++;
    if (in_ready !== 1'b1 || r_out !== 3'd5 || c_out !== 3'd5) begin
      errors++; $display("FAIL first_start: in_ready=%b r=%0d c=%0d required 1 5 5", in_ready, r_out, c_out);
    end
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_data = DW'(i);
      step();
    end
    in_valid = 0;
    checks++;
    if (count !== 5'd4) begin
      errors++; $display("FAIL reset_precount: count=%0d required 4", count);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, done, dim_err, value_err, count, r_out, c_out} !== 16'h0 || data_out !== '0) begin
      errors++; $display("FAIL reset_mid_collect: in_ready=%b count=%0d r=%0d c=%0d data_nonzero=%b",
                         in_ready, count, r_out, c_out, data_out != '0);
    end
    step();
    checks++;
    if (in_ready !== 1'b0 || count !== 5'd0) begin
      errors++; $display("FAIL reset_hold: in_ready=%b count=%0d required 0 0", in_ready, count);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_normal();
    clear_exp();
    start = 1; r_in = 2; c_in = 3;
    step();
    start = 0;
    checks++;
    if (in_ready !== 1'b1 || count !== 5'd0 || done !== 1'b0) begin
      errors++; $display("FAIL normal_enter: in_ready=%b count=%0d done=%b required 1 0 0", in_ready, count, done);
    end
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1; in_data = DW'(i); exp_slots[i-1] = i;
      step();
      if (i == 5) begin
        checks++;
        if (done !== 1'b0 || count !== 5'd5) begin
          errors++; $display("FAIL normal_early_done: done=%b count=%0d required 0 5", done, count);
        end
      end
    end
    in_valid = 0;
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0 || count !== 5'd6 || r_out !== 3'd2 || c_out !== 3'd3) begin
      errors++; $display("FAIL normal_done: done=%b in_ready=%b count=%0d r=%0d c=%0d required 1 0 6 2 3",
                         done, in_ready, count, r_out, c_out);
    end
    checks++;
    if (data_out !== exp_vec()) begin
      errors++; $display("FAIL normal_data: got %h required %h", data_out, exp_vec());
    end
    ack = 1;
    step();
    ack = 0;
    checks++;
    if (done !== 1'b0 || data_out !== exp_vec()) begin
      errors++; $display("FAIL normal_ack: done=%b data_kept=%b required 0 1", done, data_out === exp_vec());
    end
  endtask

  task automatic test_range();
    clear_exp();
    start = 1; r_in = 1; c_in = 2;
    step();
    start = 0;
    in_valid = 1; in_data = 4; exp_slots[0] = 4;
    step();
    in_data = 12;
    step();
    checks++;
    if (value_err !== 1'b1 || count !== 5'd1) begin
      errors++; $display("FAIL range_pulse: value_err=%b count=%0d required 1 1", value_err, count);
    end
    in_data = 7; exp_slots[1] = 7;
    step();
    in_valid = 0;
    checks++;
    if (value_err !== 1'b0) begin
      errors++; $display("FAIL range_pulse_width: value_err=%b required 0", value_err);
    end
    checks++;
    if (done !== 1'b1 || count !== 5'd2 || data_out !== exp_vec()) begin
      errors++; $display("FAIL range_done: done=%b count=%0d data=%h required 1 2 %h", done, count, data_out, exp_vec());
    end
    ack = 1;
    step();
    ack = 0;
  endtask

  task automatic test_dim_err();
    start = 1; r_in = 0; c_in = 3;
    step();
    start = 0;
    checks++;
    if (dim_err !== 1'b1 || in_ready !== 1'b0 || r_out !== 3'd1 || c_out !== 3'd2) begin
      errors++; $display("FAIL dim_zero: dim_err=%b in_ready=%b r=%0d c=%0d required 1 0 1 2", dim_err, in_ready, r_out, c_out);
    end
    in_valid = 1; in_data = 15;
    step();
    in_valid = 0;
    checks++;
    if (value_err !== 1'b0 || dim_err !== 1'b1) begin
      errors++; $display("FAIL dim_hold: value_err=%b dim_err=%b required 0 1", value_err, dim_err);
    end
    ack = 1;
    step();
    ack = 0;
    checks++;
    if (dim_err !== 1'b0) begin
      errors++; $display("FAIL dim_ack1: dim_err=%b required 0", dim_err);
    end
    start = 1; r_in = 6; c_in = 1;
    step();
    start = 0;
    checks++;
    if (dim_err !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL dim_six: dim_err=%b in_ready=%b required 1 0", dim_err, in_ready);
    end
    ack = 1;
    step();
    ack = 0;
    checks++;
    if (dim_err !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL dim_ack2: dim_err=%b in_ready=%b required 0 0", dim_err, in_ready);
    end
  endtask

  task automatic test_abort();
    start = 1; r_in = 5; c_in = 5;
    step();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = DW'(3 + 2*i);
      step();
    end
    checks++;
    if (count !== 5'd3) begin
      errors++; $display("FAIL abort_pre: count=%0d required 3", count);
    end
    abort = 1; in_valid = 1; in_data = 2;
    step();
    abort = 0;
    checks++;
    if (count !== 5'd0 || data_out !== '0 || in_ready !== 1'b0 || done !== 1'b0 || dim_err !== 1'b0) begin
      errors++; $display("FAIL abort_clear: count=%0d data_nonzero=%b in_ready=%b done=%b", count, data_out != '0, in_ready, done);
    end
    step();
    in_valid = 0;
    checks++;
    if (count !== 5'd0 || value_err !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_idle: count=%0d value_err=%b in_ready=%b required 0 0 0", count, value_err, in_ready);
    end
  endtask

  task automatic test_full();
    int n;
    clear_exp();
    start = 1; r_in = 5; c_in = 5;
    step();
    start = 0;
    n = 0;
    for (int cyc = 0; cyc < 49; cyc++) begin
      if (cyc % 2 == 0) begin
        in_valid = 1; in_data = DW'((n % 9) + 1); exp_slots[n] = (n % 9) + 1; n++;
      end else begin
        in_valid = 0;
      end
      step();
      if (n == 24 && cyc % 2 == 0) begin
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
          errors++; $display("FAIL full_24: done=%b in_ready=%b required 0 1", done, in_ready);
        end
      end
    end
    in_valid = 0;
    checks++;
    if (done !== 1'b1 || count !== 5'd25 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_done: done=%b count=%0d in_ready=%b required 1 25 0", done, count, in_ready);
    end
    checks++;
    if (data_out !== exp_vec()) begin
      errors++; $display("FAIL full_data: got %h required %h", data_out, exp_vec());
    end
    in_valid = 1; in_data = 3; start = 1; r_in = 2; c_in = 2;
    step();
    step();
    in_valid = 0; start = 0;
    checks++;
    if (done !== 1'b1 || count !== 5'd25 || data_out !== exp_vec() || r_out !== 3'd5 || value_err !== 1'b0) begin
      errors++; $display("FAIL full_hold: done=%b count=%0d r=%0d value_err=%b required 1 25 5 0", done, count, r_out, value_err);
    end
    ack = 1;
    step();
    ack = 0;
    checks++;
    if (done !== 1'b0 || count !== 5'd25) begin
      errors++; $display("FAIL full_ack: done=%b count=%0d required 0 25", done, count);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_range();
    test_dim_err();
    test_abort();
    test_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_input_collector.md
MATRIX_INPUT_COLLECTOR -- requirements
Module: matrix_input_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 9, element width in bits.
REQ-002 Parameter MAX_VAL, default 9, largest legal element value (unsigned).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a new matrix; sampled only in IDLE.
REQ-006 r_in  input  3  requested row count; legal range 1..5.
REQ-007 c_in  input  3  requested column count; legal range 1..5.
REQ-008 in_valid  input  1  element offered on in_data.
REQ-009 in_data  input  DATA_WIDTH  element value, unsigned.
REQ-010 in_ready  output  1  block can accept an element this cycle.
REQ-011 ack  input  1  consumer releases DONE or ERROR state.
REQ-012 abort  input  1  cancel the current operation from any state.
REQ-013 data_out  output  25*DATA_WIDTH  element k on bits [k*DATA_WIDTH +: DATA_WIDTH], k=0..24.
REQ-014 r_out, c_out  output  3 each  latched dimensions of the current matrix.
REQ-015 count  output  5  number of elements accepted so far.
REQ-016 done  output  1  level: matrix complete, data_out valid; drives the downstream ordering stage's en.
REQ-017 dim_err  output  1  level: illegal dimensions requested.
REQ-018 value_err  output  1  one-cycle pulse: offered element rejected.

Function
REQ-019 FSM states SHALL be IDLE, COLLECT, DONE, ERROR; all outputs registered.
REQ-020 IDLE: in_ready=0; on start with r_in and c_in both in 1..5, latch r_out/c_out, clear data_out and count to 0, go to COLLECT next cycle.
REQ-021 IDLE: on start with r_in or c_in equal to 0 or greater than 5, go to ERROR and set dim_err=1 next cycle; r_out/c_out unchanged.
REQ-022 COLLECT: in_ready=1; transfer occurs on a cycle with in_valid=1 and in_ready=1.
REQ-023 Transfer with in_data <= MAX_VAL: write the element to slot count, increment count.
REQ-024 Transfer with in_data > MAX_VAL: discard the element, leave count and data_out unchanged, pulse value_err for exactly the following cycle, remain in COLLECT.
REQ-025 Elements SHALL pack in arrival order into slots 0..r*c-1; slots r*c..24 SHALL remain 0.
REQ-026 When the accepted transfer makes count equal r_out*c_out, the next cycle SHALL enter DONE with done=1 and in_ready=0; no further element is accepted in that cycle.
REQ-027 DONE: data_out, r_out, c_out, count held stable; start and in_valid ignored; on ack, go to IDLE with done=0 next cycle; data_out retained until the next valid start.
REQ-028 ERROR: dim_err held at 1, in_ready=0; on ack, go to IDLE with dim_err=0 next cycle.
REQ-029 abort in any state SHALL take priority over start, ack and transfers: next cycle IDLE, count=0, data_out=0, done=0, dim_err=0, in_ready=0.
REQ-030 in_valid outside COLLECT SHALL have no effect and SHALL NOT raise value_err.
REQ-031 Dimension product r*c SHALL be computed at full width (max 25) without truncation.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, in_ready=0, data_out=0, r_out=0, c_out=0, count=0, done=0, dim_err=0, value_err=0, including when asserted mid-COLLECT.
REQ-033 After reset_n deasserts, the first start SHALL be honoured on the first rising edge.

Verification
REQ-034 Reset: assert reset_n low mid-COLLECT after 4 elements -> all outputs 0 immediately, state IDLE.
REQ-035 Normal: start r_in=2 c_in=3, stream 1,2,3,4,5,6 back-to-back -> done=1 cycle after 6th transfer, slots 0..5=1..6, slots 6..24=0, r_out=2, c_out=3, count=6; ack -> done=0 next cycle.
REQ-036 Range: start 1x2, send 4, 12, 7 -> value_err pulse one cycle after 12, count=2, slots 0..1=4,7, done=1.
REQ-037 Illegal dims: start r_in=0 c_in=3, then r_in=6 c_in=1 after ack -> dim_err=1, in_ready=0 each time; ack clears dim_err.
REQ-038 Abort: start 5x5, send 3 elements, assert abort with in_valid=1 -> next cycle IDLE, count=0, data_out=0, element not stored.
REQ-039 Full size: start 5x5, 25 elements with in_valid toggling every other cycle -> done after 25th transfer, count=25, in_ready=0 in DONE, extra in_valid ignored.
